// File: rtl/mips_pkg.sv
// Shared pipeline-control definitions: fetch FSM state encodings, next-PC
// select codes and default reset/exception vectors used by fetch, decode and execute.
package mips_pkg;

    localparam int          WORD_SIZE_DEF = 32;
    localparam logic [31:0] BOOT_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_ADDR_DEF  = 32'h0000_0020;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } fetch_state_e;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_EXC  = 3'd2,
        SEL_ERET = 3'd3,
        SEL_BR   = 3'd4,
        SEL_JMP  = 3'd5,
        SEL_BOOT = 3'd6
    } npc_sel_e;

    // RUN and STEP both execute instructions and honour redirects.
    function automatic logic is_active(input fetch_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle between the fetch controller and the pipeline: PC, redirect and
// debug requests in, fetch-stage load/reset/flush controls and status out.
interface fetch_ctrl_if
    import mips_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
);
    logic                 stall;
    logic                 br_taken;
    logic                 jmp;
    logic                 exc;
    logic                 eret;
    logic                 dbg_halt;
    logic                 dbg_step;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] br_target;
    logic [WORD_SIZE-1:0] jmp_target;
    logic [WORD_SIZE-1:0] exc_pc;

    logic                 fetch_rst;
    logic                 load;
    logic                 ir_valid;
    logic                 flush;
    logic                 halted;
    logic                 in_exc;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] epc;

    modport master (
        output pc, stall, br_taken, br_target, jmp, jmp_target,
               exc, exc_pc, eret, dbg_halt, dbg_step,
        input  fetch_rst, load, addr, ir_valid, flush, halted, in_exc, epc
    );

    modport slave (
        input  pc, stall, br_taken, br_target, jmp, jmp_target,
               exc, exc_pc, eret, dbg_halt, dbg_step,
        output fetch_rst, load, addr, ir_valid, flush, halted, in_exc, epc
    );

endinterface

// File: rtl/fetch_ctrl_npc.sv
// Combinational next-PC priority mux: picks the redirect source for this
// cycle and derives the fetch load/flush/valid strobes from it.
module fetch_ctrl_npc
    import mips_pkg::*;
#(
    parameter int                   WORD_SIZE = WORD_SIZE_DEF,
    parameter logic [WORD_SIZE-1:0] BOOT_ADDR = WORD_SIZE'(BOOT_ADDR_DEF),
    parameter logic [WORD_SIZE-1:0] EXC_ADDR  = WORD_SIZE'(EXC_ADDR_DEF)
) (
    input  fetch_state_e         state,
    input  logic                 dbg_halt,
    input  logic                 in_exc,
    input  logic                 exc,
    input  logic                 eret,
    input  logic                 br_taken,
    input  logic                 jmp,
    input  logic                 stall,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] epc,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic [WORD_SIZE-1:0] jmp_target,
    output logic                 load,
    output logic [WORD_SIZE-1:0] addr,
    output logic                 flush,
    output logic                 ir_valid,
    output logic                 take_exc,
    output logic                 take_eret
);

    npc_sel_e sel;
    logic     halt_req;

    // A halt request in RUN only yields to exc/branch/jump, not to eret or stall.
    assign halt_req = (state == ST_RUN) && dbg_halt;

    always_comb begin
        sel = SEL_SEQ;
        if (state == ST_BOOT) begin
            sel = SEL_BOOT;
        end else if (!is_active(state)) begin
            sel = SEL_HOLD;
        end else if (exc && !in_exc) begin
            sel = SEL_EXC;
        end else if (eret && in_exc && !halt_req) begin
            sel = SEL_ERET;
        end else if (br_taken) begin
            sel = SEL_BR;
        end else if (jmp) begin
            sel = SEL_JMP;
        end else if (halt_req || stall) begin
            sel = SEL_HOLD;
        end
    end

    always_comb begin
        load      = 1'b0;
        addr      = pc;
        flush     = 1'b0;
        ir_valid  = 1'b1;
        take_exc  = 1'b0;
        take_eret = 1'b0;
        case (sel)
            SEL_BOOT: begin
                addr     = BOOT_ADDR;
                ir_valid = 1'b0;
            end
            SEL_HOLD: begin
                load     = 1'b1;
                ir_valid = 1'b0;
            end
            SEL_EXC: begin
                load     = 1'b1;
                addr     = EXC_ADDR;
                flush    = 1'b1;
                take_exc = 1'b1;
            end
            SEL_ERET: begin
                load      = 1'b1;
                addr      = epc;
                flush     = 1'b1;
                take_eret = 1'b1;
            end
            SEL_BR: begin
                load  = 1'b1;
                addr  = br_target;
                flush = 1'b1;
            end
            SEL_JMP: begin
                load = 1'b1;
                addr = jmp_target;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: BOOT/RUN/HALT/STEP sequencing, exception entry/return
// bookkeeping (in_exc, epc) and the registered fetch-reset/halted status.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter int                   WORD_SIZE = WORD_SIZE_DEF,
    parameter logic [WORD_SIZE-1:0] BOOT_ADDR = WORD_SIZE'(BOOT_ADDR_DEF),
    parameter logic [WORD_SIZE-1:0] EXC_ADDR  = WORD_SIZE'(EXC_ADDR_DEF)
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.slave  bus
);

    fetch_state_e         state_q, state_d;
    logic                 in_exc_q, in_exc_d;
    logic                 fetch_rst_q, fetch_rst_d;
    logic                 halted_q, halted_d;
    logic [WORD_SIZE-1:0] epc_q, epc_d;

    logic                 npc_load;
    logic [WORD_SIZE-1:0] npc_addr;
    logic                 npc_flush;
    logic                 npc_ir_valid;
    logic                 take_exc;
    logic                 take_eret;

    fetch_ctrl_npc #(
        .WORD_SIZE (WORD_SIZE),
        .BOOT_ADDR (BOOT_ADDR),
        .EXC_ADDR  (EXC_ADDR)
    ) u_npc (
        .state      (state_q),
        .dbg_halt   (bus.dbg_halt),
        .in_exc     (in_exc_q),
        .exc        (bus.exc),
        .eret       (bus.eret),
        .br_taken   (bus.br_taken),
        .jmp        (bus.jmp),
        .stall      (bus.stall),
        .pc         (bus.pc),
        .epc        (epc_q),
        .br_target  (bus.br_target),
        .jmp_target (bus.jmp_target),
        .load       (npc_load),
        .addr       (npc_addr),
        .flush      (npc_flush),
        .ir_valid   (npc_ir_valid),
        .take_exc   (take_exc),
        .take_eret  (take_eret)
    );

    always_comb begin
        state_d  = state_q;
        in_exc_d = in_exc_q;
        epc_d    = epc_q;
        if (take_exc) begin
            in_exc_d = 1'b1;
            epc_d    = bus.exc_pc;
        end else if (take_eret) begin
            in_exc_d = 1'b0;
        end
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = bus.dbg_halt ? ST_HALT : ST_RUN;
            ST_HALT: begin
                if (bus.dbg_step) begin
                    state_d = ST_STEP;
                end else if (!bus.dbg_halt) begin
                    state_d = ST_RUN;
                end
            end
            // A stalled step has not retired its instruction yet, so keep stepping.
            ST_STEP: state_d = npc_ir_valid ? ST_HALT : ST_STEP;
            default: state_d = ST_BOOT;
        endcase
        fetch_rst_d = (state_d == ST_BOOT);
        halted_d    = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            in_exc_q    <= 1'b0;
            epc_q       <= '0;
            fetch_rst_q <= 1'b1;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_exc_q    <= in_exc_d;
            epc_q       <= epc_d;
            fetch_rst_q <= fetch_rst_d;
            halted_q    <= halted_d;
        end
    end

    // The boot vector is only presented once reset has been released.
    assign bus.addr      = rst_n ? npc_addr : '0;
    assign bus.load      = npc_load;
    assign bus.flush     = npc_flush;
    assign bus.ir_valid  = npc_ir_valid;
    assign bus.fetch_rst = fetch_rst_q;
    assign bus.halted    = halted_q;
    assign bus.in_exc    = in_exc_q;
    assign bus.epc       = epc_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter WORD_SIZE, 32, width of PC and targets.
REQ-002 Parameter BOOT_ADDR, 32'h00000000, word address loaded into fetch after reset.
REQ-003 Parameter EXC_ADDR, 32'h00000020, exception vector word address.
REQ-004 Port clk  in  1  sole clock; all state on rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port pc  in  WORD_SIZE  current fetch PC.
REQ-007 Port stall  in  1  downstream cannot accept instruction; hold PC.
REQ-008 Port br_taken / br_target  in  1 / WORD_SIZE  resolved taken branch and its target.
REQ-009 Port jmp / jmp_target  in  1 / WORD_SIZE  decoded jump and its target.
REQ-010 Port exc / exc_pc  in  1 / WORD_SIZE  exception request and faulting PC.
REQ-011 Port eret  in  1  return from exception.
REQ-012 Port dbg_halt / dbg_step  in  1 / 1  debug halt level; single-step pulse.
REQ-013 Port fetch_rst  out  1  drives fetch stage reset.
REQ-014 Port load / addr  out  1 / WORD_SIZE  fetch PC load strobe and value (combinational).
REQ-015 Port ir_valid / flush  out  1 / 1  fetched instruction valid; squash younger stages.
REQ-016 Port halted / in_exc / epc  out  1 / 1 / WORD_SIZE  debug-halted; in handler; saved PC.

Function
REQ-017 States BOOT, RUN, HALT, STEP; 2-bit state register.
REQ-018 BOOT: fetch_rst=1, load=0, ir_valid=0; next state RUN unconditionally.
REQ-019 RUN/STEP redirect priority, highest first: exc (if in_exc=0), eret (if in_exc=1), br_taken, jmp, stall, sequential.
REQ-020 exc accepted: load=1, addr=EXC_ADDR, flush=1; at edge epc<=exc_pc, in_exc<=1.
REQ-021 exc while in_exc=1 ignored (no load, no flush, epc unchanged).
REQ-022 eret with in_exc=1: load=1, addr=epc, flush=1; at edge in_exc<=0; eret with in_exc=0 ignored.
REQ-023 br_taken: load=1, addr=br_target, flush=1; jmp (no br_taken): load=1, addr=jmp_target, flush=0.
REQ-024 stall with no redirect: load=1, addr=pc (hold); ir_valid=0.
REQ-025 Sequential (no event): load=0, fetch increments; ir_valid=1.
REQ-026 Redirect takes effect at next edge; target instruction on ir the following cycle with ir_valid=1.
REQ-027 RUN with dbg_halt=1: PC held (load=1, addr=pc) unless exc/br/jmp redirect, which wins; next state HALT.
REQ-028 HALT: load=1, addr=pc, ir_valid=0, halted=1; all redirect inputs ignored.
REQ-029 HALT with dbg_step=1: next STEP; HALT with dbg_halt=0: next RUN.
REQ-030 STEP: one RUN cycle (all RUN rules apply, ir_valid=1 unless stall); next HALT, or remain STEP if stall=1.
REQ-031 flush=0 and ir_valid=0 in BOOT and HALT.
REQ-032 Simultaneous exc and br_taken: exception wins, branch discarded.

Reset
REQ-033 rst_n=0 asynchronously forces state=BOOT, in_exc=0, epc=0.
REQ-034 During reset outputs: fetch_rst=1, load=0, addr=0, ir_valid=0, flush=0, halted=0.
REQ-035 Reset mid-exception or mid-halt discards all state; first cycle after release is BOOT.

Structure
REQ-036 State encodings and vector defaults reside in shared package mips_pkg, reused by decode/execute.
REQ-037 Single module; next-PC mux as separate sub-module fetch_ctrl_npc (priority mux, combinational).

Verification
REQ-038 Release rst_n -> one cycle fetch_rst=1, then pc=0,1,2 with ir_valid=1.
REQ-039 br_taken=1, br_target=0x40 at pc=5 -> load=1, addr=0x40, flush=1; next cycle pc=0x40.
REQ-040 exc=1, exc_pc=7, br_taken=1 same cycle -> addr=0x20, epc=7, in_exc=1; second exc ignored; eret -> pc=7, in_exc=0.
REQ-041 stall=1 for 3 cycles at pc=9 -> pc stays 9, ir_valid=0; release -> pc=10.
REQ-042 dbg_halt=1 at pc=3 -> halted=1, pc held at 3; dbg_step pulse -> pc=4, back to HALT; dbg_halt=0 -> RUN.
REQ-043 rst_n=0 asynchronously while in_exc=1 in HALT -> halted=0, in_exc=0 immediately; BOOT on release.
